// File: rtl/parity5_pkg.sv
// Shared types and default constants for the parity5 checker slice.
package parity5_pkg;

    localparam int unsigned WORD_W     = 5;
    localparam int unsigned ERR_W_DEF  = 8;
    localparam int unsigned WINDOW_DEF = 16;
    localparam int unsigned WIN_W_DEF  = 5;

    // One data word: bit 0 is x0, bit 4 is x4.
    typedef logic [WORD_W-1:0] word_t;

    // Summary-window tracking state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } win_state_t;

endpackage : parity5_pkg

// File: rtl/parity5_core.sv
// Combinational 5-input XOR: odd parity of one data word.
module parity5_core
    import parity5_pkg::*;
(
    input  logic [WORD_W-1:0] i_data,
    output logic              o_par_c
);

    // Reduction XOR over x0..x4.
    always_comb begin
        o_par_c = ^i_data;
    end

endmodule : parity5_core

// File: rtl/parity5_checker.sv
// Stream parity checker: one-entry result register, saturating error
// count and a per-window mismatch summary.
module parity5_checker
    import parity5_pkg::*;
#(
    parameter int unsigned ERR_W  = ERR_W_DEF,
    parameter int unsigned WINDOW = WINDOW_DEF,
    parameter int unsigned WIN_W  = WIN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_par,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_par,
    output logic              out_err,
    input  logic              clr,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              win_done,
    output logic [WIN_W-1:0]  win_errs
);

    logic              w_par;
    logic              w_err;
    logic              w_accept;

    logic              r_out_valid;
    logic              r_out_par;
    logic              r_out_err;
    logic [ERR_W-1:0]  r_err_cnt;
    logic              r_win_done;
    logic [WIN_W-1:0]  r_win_errs;
    logic [WIN_W-1:0]  r_word_cnt;
    logic [WIN_W-1:0]  r_win_acc;
    win_state_t        r_state;

    parity5_core u_core (
        .i_data  (in_data),
        .o_par_c (w_par)
    );

    // Handshake: the result register frees up when empty or being drained.
    always_comb begin
        in_ready = ~r_out_valid | out_ready;
        w_accept = in_valid & in_ready;
        w_err    = w_par ^ in_par;
    end

    // One-entry result register; reload on accept, drain on handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_par   <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_par   <= w_par;
            r_out_err   <= w_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating error count; clr wins over a same-cycle mismatch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_err && (r_err_cnt != {ERR_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    // Window FSM: count words and mismatches, pulse a summary every WINDOW words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
            r_win_acc  <= '0;
            r_win_done <= 1'b0;
            r_win_errs <= '0;
        end else if (clr) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
            r_win_acc  <= '0;
            r_win_done <= 1'b0;
            r_win_errs <= '0;
        end else begin
            r_win_done <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        // WINDOW >= 2, so the first word can never close a window.
                        r_state    <= ST_RUN;
                        r_word_cnt <= WIN_W'(1);
                        r_win_acc  <= WIN_W'(w_err);
                    end
                    ST_RUN: begin
                        if (r_word_cnt == WIN_W'(WINDOW - 1)) begin
                            r_state    <= ST_IDLE;
                            r_word_cnt <= '0;
                            r_win_acc  <= '0;
                            r_win_done <= 1'b1;
                            r_win_errs <= r_win_acc + WIN_W'(w_err);
                        end else begin
                            r_word_cnt <= r_word_cnt + WIN_W'(1);
                            r_win_acc  <= r_win_acc + WIN_W'(w_err);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Registered outputs.
    always_comb begin
        out_valid = r_out_valid;
        out_par   = r_out_par;
        out_err   = r_out_err;
        err_cnt   = r_err_cnt;
        win_done  = r_win_done;
        win_errs  = r_win_errs;
    end

endmodule : parity5_checker

// File: tb/tb_parity5_checker.sv
// Randomized and directed scoreboard bench for parity5_checker.
module tb_parity5_checker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic       in_par;
    logic       out_valid;
    logic       out_ready;
    logic       out_par;
    logic       out_err;
    logic       clr;
    logic [7:0] err_cnt;
    logic       win_done;
    logic [4:0] win_errs;

    // Second instance with a 2-bit counter, driven by the same stream.
    logic       s_in_ready;
    logic       s_out_valid;
    logic       s_out_par;
    logic       s_out_err;
    logic [1:0] s_err_cnt;
    logic       s_win_done;
    logic [4:0] s_win_errs;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_seen = 0;
    bit chk_en   = 0;

    // Reference model state
    typedef struct { bit par; bit err; } res_t;
    res_t q[$];
    int   m_err;
    int   m_words;
    int   m_wacc;
    bit   m_done;
    int   m_win_errs;

    parity5_checker u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_par(in_par), .out_valid(out_valid),
        .out_ready(out_ready), .out_par(out_par), .out_err(out_err),
        .clr(clr), .err_cnt(err_cnt), .win_done(win_done), .win_errs(win_errs)
    );

    parity5_checker #(.ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_par(in_par), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_par(s_out_par), .out_err(s_out_err),
        .clr(clr), .err_cnt(s_err_cnt), .win_done(s_win_done), .win_errs(s_win_errs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v)
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
        else
            n_pass++;
    endtask

    function automatic bit parity_of(input logic [4:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Monitor and reference model: check what the last edge produced,
    // then advance the model by what the coming edge will do.
    always @(negedge clk) begin
        bit exp_ready;
        bit acc;
        bit p;
        if (chk_en) begin
            exp_ready = (q.size() == 0) || out_ready;
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            if (q.size() != 0) begin
                chk("out_par", 32'(out_par), 32'(q[0].par));
                chk("out_err", 32'(out_err), 32'(q[0].err));
            end
            chk("err_cnt", 32'(err_cnt), 32'(sat(m_err, 255)));
            chk("sat_err_cnt", 32'(s_err_cnt), 32'(sat(m_err, 3)));
            chk("win_done", 32'(win_done), 32'(m_done));
            chk("win_errs", 32'(win_errs), 32'(m_win_errs));
            if (win_done === 1'b1) done_seen++;
        end
        exp_ready = (q.size() == 0) || out_ready;
        acc = in_valid && exp_ready;
        if (!rst_n) begin
            q.delete();
            m_err = 0; m_words = 0; m_wacc = 0; m_done = 0; m_win_errs = 0;
            chk_en = 1;
        end else if (chk_en) begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            p = parity_of(in_data);
            if (acc) q.push_back('{par: p, err: p ^ in_par});
            m_done = 0;
            if (clr) begin
                m_err = 0; m_words = 0; m_wacc = 0; m_win_errs = 0;
            end else if (acc) begin
                m_err  += int'(p ^ in_par);
                m_wacc += int'(p ^ in_par);
                m_words++;
                if (m_words == 16) begin
                    m_done = 1; m_win_errs = m_wacc; m_words = 0; m_wacc = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Offer one word and wait (bounded) until it is taken.
    task automatic send(input logic [4:0] d, input logic p);
        in_valid = 1'b1; in_data = d; in_par = p;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        n_checks++;
        $display("FAIL send_timeout at cycle %0d: got no accept expected accept within 50 cycles", cyc);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input bit mismatch);
        logic [4:0] d;
        d = 5'($urandom);
        send(d, parity_of(d) ^ mismatch);
    endtask

    task automatic pulse_clr();
        clr = 1'b1; step(); clr = 1'b0;
    endtask

    initial begin
        int t0;
        int d0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_par = 1'b0;
        out_ready = 1'b1; clr = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Basic: matching word then mismatching word.
        send(5'b10110, 1'b1);
        send(5'b00111, 1'b0);
        step(); step();

        // Backpressure: hold a result, keep offering a word for 5 cycles.
        out_ready = 1'b0;
        send_word(1'b0);
        in_valid = 1'b1; in_data = 5'b11001; in_par = 1'b0;
        for (int k = 0; k < 5; k++) step();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();

        // Streaming: 20 back-to-back words, mismatches on 3, 7, 15.
        pulse_clr();
        t0 = cyc; d0 = done_seen;
        for (int i = 1; i <= 20; i++) send_word(i == 3 || i == 7 || i == 15);
        chk("stream_cycles", 32'(cyc - t0), 32'd20);
        step();
        chk("stream_done_pulses", 32'(done_seen - d0), 32'd1);
        chk("stream_win_errs", 32'(win_errs), 32'd3);
        chk("stream_err_cnt", 32'(err_cnt), 32'd3);

        // Saturation on the 2-bit instance: five mismatches.
        pulse_clr();
        for (int i = 0; i < 5; i++) send_word(1'b1);
        step();

        // clr colliding with a mismatching accept at err_cnt=4.
        pulse_clr();
        for (int i = 0; i < 4; i++) send_word(1'b1);
        clr = 1'b1;
        send_word(1'b1);
        clr = 1'b0;
        step();
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);

        // Reset while a result is held and the window is at 9 words.
        pulse_clr();
        for (int i = 0; i < 9; i++) send_word(i[0]);
        out_ready = 1'b0;
        step(); step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        out_ready = 1'b1;
        d0 = done_seen;
        for (int i = 0; i < 15; i++) send_word(1'b0);
        step();
        chk("post_reset_no_done", 32'(done_seen - d0), 32'd0);
        send_word(1'b1);
        step();
        chk("post_reset_done", 32'(done_seen - d0), 32'd1);

        // Random traffic with occasional clr and reset.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 5'($urandom);
            in_par    = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 99) < 2);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        in_valid = 1'b0; clr = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_parity5_checker
